// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl
//   Sequencing controller for an MxN signed matrix-vector datapath made of an
//   x memory, an A memory (row-major), a MAC and a y memory. All memories have
//   a registered read with one cycle of latency. A run is:
//     1. stream x (N words), then A (M*N words) in over a valid/ready input,
//     2. issue M*N back-to-back reads into the MAC with no row bubbles,
//     3. drain the two-stage MAC/y-write pipeline,
//     4. stream the M results out over a valid/ready output, pulse done.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   start      begin a run (sampled only while idle)
//   in_valid   load word present on the datapath input
//   in_ready   controller accepts a load word (LOAD_X / LOAD_A)
//   wr_en_x    x memory write enable,  addr_x  x memory address
//   wr_en_a    A memory write enable,  addr_a  A memory address
//   mac_en     MAC update enable
//   clear_acc  MAC loads the product instead of accumulating
//   wr_en_y    y memory write enable (captures MAC output), addr_y y address
//   out_valid  y read data valid to consumer
//   out_ready  consumer accepts y word
//   busy       controller is not idle
//   done       one-cycle pulse on the final output handshake
module mvm_seq_ctrl #(
  parameter int unsigned M    = 3,
  parameter int unsigned N    = 3,
  parameter int unsigned AW_X = 2,
  parameter int unsigned AW_A = 4,
  parameter int unsigned AW_Y = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en_x,
  output logic [AW_X-1:0] addr_x,
  output logic            wr_en_a,
  output logic [AW_A-1:0] addr_a,
  output logic            mac_en,
  output logic            clear_acc,
  output logic            wr_en_y,
  output logic [AW_Y-1:0] addr_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  localparam int unsigned MN = M * N;
  localparam int unsigned KW = (MN > 1) ? $clog2(MN) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(MN - 1);
  localparam logic [KW-1:0] X_LAST = KW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_A,
    COMPUTE,
    DRAIN,
    OUTPUT
  } state_t;

  state_t state, state_next;

  // Shared word counter: load count in LOAD_X/LOAD_A, issue index k in COMPUTE.
  logic [KW-1:0] cnt;
  // Column/row of the current issue, tracked alongside k to avoid a divider.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          drain_cnt;

  // Output side: element index and the registered valid that implements the
  // one-cycle read bubble after every address change.
  logic [RW-1:0] out_idx;
  logic          out_vld;

  // Stage 1: cycle after an issue, memory read data is at the MAC inputs.
  logic          s1_vld;
  logic          s1_clr;
  logic          s1_last;
  logic [RW-1:0] s1_row;
  // Stage 2: cycle after the MAC updated on a row's last column; the y memory
  // captures the finished accumulator here.
  logic          s2_vld;
  logic [RW-1:0] s2_row;

  logic          out_last;

  always_comb begin
    out_last = (out_idx == R_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_X;
        end
      end
      LOAD_X: begin
        if (in_valid && (cnt == X_LAST)) begin
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        if (in_valid && (cnt == K_LAST)) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt == K_LAST) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_vld && out_ready && out_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. The MAC and y-write controls come straight from the
  // pipeline registers so they keep running through DRAIN and are naturally
  // zero in every other state once the pipeline has emptied.
  always_comb begin
    in_ready  = 1'b0;
    wr_en_x   = 1'b0;
    addr_x    = '0;
    wr_en_a   = 1'b0;
    addr_a    = '0;
    mac_en    = s1_vld;
    clear_acc = s1_vld & s1_clr;
    wr_en_y   = s2_vld;
    addr_y    = s2_vld ? AW_Y'(s2_row) : '0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      LOAD_X: begin
        in_ready = 1'b1;
        wr_en_x  = in_valid;
        addr_x   = AW_X'(cnt);
      end
      LOAD_A: begin
        in_ready = 1'b1;
        wr_en_a  = in_valid;
        addr_a   = AW_A'(cnt);
      end
      COMPUTE: begin
        addr_a = AW_A'(cnt);
        addr_x = AW_X'(col);
      end
      OUTPUT: begin
        addr_y    = AW_Y'(out_idx);
        out_valid = out_vld;
        done      = out_vld & out_ready & out_last;
      end
      default: begin
      end
    endcase
  end

  // Counters and MAC/y pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      out_idx   <= '0;
      out_vld   <= 1'b0;
      s1_vld    <= 1'b0;
      s1_clr    <= 1'b0;
      s1_last   <= 1'b0;
      s1_row    <= '0;
      s2_vld    <= 1'b0;
      s2_row    <= '0;
    end else begin
      s1_vld  <= (state == COMPUTE);
      s1_clr  <= (col == '0);
      s1_last <= (col == C_LAST);
      s1_row  <= row;
      s2_vld  <= s1_vld & s1_last;
      s2_row  <= s1_row;

      case (state)
        IDLE: begin
          cnt       <= '0;
          col       <= '0;
          row       <= '0;
          drain_cnt <= 1'b0;
          out_idx   <= '0;
          out_vld   <= 1'b0;
        end
        LOAD_X: begin
          if (in_valid) begin
            cnt <= (cnt == X_LAST) ? '0 : cnt + 1'b1;
          end
        end
        LOAD_A: begin
          if (in_valid) begin
            cnt <= (cnt == K_LAST) ? '0 : cnt + 1'b1;
          end
        end
        COMPUTE: begin
          cnt <= (cnt == K_LAST) ? '0 : cnt + 1'b1;
          if (col == C_LAST) begin
            col <= '0;
            row <= (row == R_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          out_idx   <= '0;
          out_vld   <= 1'b0;
        end
        OUTPUT: begin
          // First cycle at a new address only launches the y read; valid
          // rises once the registered read data is present.
          if (!out_vld) begin
            out_vld <= 1'b1;
          end else if (out_ready) begin
            out_vld <= 1'b0;
            out_idx <= out_last ? '0 : out_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Testbench for mvm_seq_ctrl: wraps the controller with a behavioural
// datapath (x/A/y memories with registered read, 16-bit wrapping MAC) and
// checks results, write sequences, latency and handshake behaviour.
module tb_mvm_seq_ctrl;

  localparam int unsigned M    = 3;
  localparam int unsigned N    = 3;
  localparam int unsigned AW_X = 2;
  localparam int unsigned AW_A = 4;
  localparam int unsigned AW_Y = 2;
  localparam int unsigned NW   = N + M * N;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic            wr_en_x;
  logic [AW_X-1:0] addr_x;
  logic            wr_en_a;
  logic [AW_A-1:0] addr_a;
  logic            mac_en;
  logic            clear_acc;
  logic            wr_en_y;
  logic [AW_Y-1:0] addr_y;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  logic [16:0]     all_outs;
  assign all_outs = {in_ready, wr_en_x, addr_x, wr_en_a, addr_a, mac_en,
                     clear_acc, wr_en_y, addr_y, out_valid, busy, done};

  always #5 clk = ~clk;

  mvm_seq_ctrl #(.M(M), .N(N), .AW_X(AW_X), .AW_A(AW_A), .AW_Y(AW_Y)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en_x  (wr_en_x),
    .addr_x   (addr_x),
    .wr_en_a  (wr_en_a),
    .addr_a   (addr_a),
    .mac_en   (mac_en),
    .clear_acc(clear_acc),
    .wr_en_y  (wr_en_y),
    .addr_y   (addr_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Behavioural datapath
  logic signed [7:0]  data_in;
  logic               poison;
  logic signed [7:0]  x_mem [2**AW_X];
  logic signed [7:0]  a_mem [2**AW_A];
  logic signed [15:0] y_mem [2**AW_Y];
  logic signed [7:0]  x_rd, a_rd;
  logic signed [15:0] acc, y_rd;

  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 2**AW_Y; i++) y_mem[i] <= 16'sh7EAD;
      acc <= 16'sh5A5A;
    end else begin
      if (wr_en_x) x_mem[addr_x] <= data_in;
      if (wr_en_a) a_mem[addr_a] <= data_in;
      x_rd <= x_mem[addr_x];
      a_rd <= a_mem[addr_a];
      if (mac_en) acc <= clear_acc ? a_rd * x_rd : acc + a_rd * x_rd;
      if (wr_en_y) y_mem[addr_y] <= acc;
      y_rd <= y_mem[addr_y];
    end
  end

  // Cycle counter and cumulative monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wx_q[$], wa_q[$], wy_q[$], res_q[$];
  int mac_tot = 0, clr_tot = 0, rdy_tot = 0, done_tot = 0, viol_tot = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en_x) wx_q.push_back(int'(addr_x));
      if (wr_en_a) wa_q.push_back(int'(addr_a));
      if (wr_en_y) wy_q.push_back(int'(addr_y));
      if (mac_en) mac_tot++;
      if (mac_en && clear_acc) clr_tot++;
      if (in_ready) rdy_tot++;
      if (out_valid && out_ready) res_q.push_back(int'(y_rd));
      if (done) done_tot++;
      if (wr_en_x && wr_en_a) viol_tot++;
      if ((wr_en_x || wr_en_a) && !(in_ready && in_valid)) viol_tot++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0][7:0]    x;
    logic [M*N-1:0][7:0]  a;
    logic [M-1:0][15:0]   y;    // expected results
    logic [1:0]           gap;  // 0 continuous, 1 alternate (low first), 2 random
    logic [1:0]           bp;   // 0 always ready, 1 hold y[1] 5 cycles, 2 random
    logic                 poke; // pulse start during LOAD_A and OUTPUT
  } vec_t;

  vec_t tbl [7];

  function automatic logic [M-1:0][15:0] ref_y(input logic [N-1:0][7:0] x,
                                               input logic [M*N-1:0][7:0] a);
    logic [M-1:0][15:0] r;
    int s;
    for (int i = 0; i < int'(M); i++) begin
      s = 0;
      for (int j = 0; j < int'(N); j++)
        s += int'($signed(a[i*N+j])) * int'($signed(x[j]));
      r[i] = 16'(s);
    end
    return r;
  endfunction

  function automatic logic [7:0] word(input vec_t v, input int i);
    if (i < int'(N)) return v.x[i];
    return v.a[i-N];
  endfunction

  task automatic run(input vec_t v, input string tag);
    int bx, ba, by, br, b_mac, b_clr, b_rdy, b_done, b_viol;
    int t0, idx, load_cycles, oc, first_ov;
    bit got, bp_done, poked;

    oc = 0;
    while (busy && oc < 200) begin @(posedge clk); #1; oc++; end
    check({tag, "_idle_before"}, busy, 0);

    poison = 1'b1;
    @(posedge clk); #1;
    poison = 1'b0;

    bx = wx_q.size(); ba = wa_q.size(); by = wy_q.size(); br = res_q.size();
    b_mac = mac_tot; b_clr = clr_tot; b_rdy = rdy_tot;
    b_done = done_tot; b_viol = viol_tot;

    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0;
    load_cycles = 0;
    while (idx < int'(NW) && load_cycles < 200) begin
      logic iv;
      case (v.gap)
        2'd0:    iv = 1'b1;
        2'd1:    iv = ((load_cycles % 2) == 1);
        default: iv = 1'($urandom_range(0, 1));
      endcase
      in_valid = iv;
      data_in  = iv ? word(v, idx) : 8'($urandom);
      start    = v.poke && (idx == int'(N) + 2);
      @(posedge clk); #1;
      if (iv) idx++;
      load_cycles++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_load_words"}, idx, NW);

    got = 0; bp_done = 0; poked = 0; first_ov = -1; oc = 0;
    while (!got && oc < 400) begin
      start = 1'b0;
      out_ready = (v.bp == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.poke && !poked && out_valid) begin
        start = 1'b1;
        poked = 1;
      end
      if (v.bp == 2'd1 && !bp_done && out_valid && addr_y == AW_Y'(1)) begin
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          check({tag, "_bp_valid"}, out_valid, 1);
          check({tag, "_bp_addr"}, addr_y, 1);
          check({tag, "_bp_data"}, y_rd, $signed(v.y[1]));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_bp_release"}, out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_bubble_valid"}, out_valid, 0);
        check({tag, "_bubble_addr"}, addr_y, 2);
        @(posedge clk); #1;
        bp_done = 1;
        oc += 7;
      end else begin
        @(negedge clk);
        if (out_valid && first_ov < 0) first_ov = cyc - t0;
        if (done) got = 1;
        @(posedge clk); #1;
        oc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, got, 1);

    repeat (2) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulses"}, done_tot - b_done, 1);
    check({tag, "_mac_cycles"}, mac_tot - b_mac, M * N);
    check({tag, "_clear_cycles"}, clr_tot - b_clr, M);
    check({tag, "_ready_cycles"}, rdy_tot - b_rdy, load_cycles);
    check({tag, "_wr_protocol"}, viol_tot - b_viol, 0);
    check({tag, "_first_valid"}, first_ov, load_cycles + M * N + 4);

    check({tag, "_wx_count"}, wx_q.size() - bx, N);
    check({tag, "_wa_count"}, wa_q.size() - ba, M * N);
    check({tag, "_wy_count"}, wy_q.size() - by, M);
    check({tag, "_res_count"}, res_q.size() - br, M);
    if (wx_q.size() >= bx + int'(N))
      for (int i = 0; i < int'(N); i++) check({tag, "_wx_addr"}, wx_q[bx+i], i);
    if (wa_q.size() >= ba + int'(M * N))
      for (int i = 0; i < int'(M * N); i++) check({tag, "_wa_addr"}, wa_q[ba+i], i);
    if (wy_q.size() >= by + int'(M))
      for (int i = 0; i < int'(M); i++) check({tag, "_wy_addr"}, wy_q[by+i], i);
    if (res_q.size() >= br + int'(M))
      for (int i = 0; i < int'(M); i++)
        check({tag, "_y"}, res_q[br+i], int'($signed(v.y[i])));
  endtask

  task automatic reset_mid_compute(input vec_t v);
    int oc;
    oc = 0;
    while (busy && oc < 200) begin @(posedge clk); #1; oc++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(NW); i++) begin
      in_valid = 1'b1;
      data_in  = word(v, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_mac_en", mac_en, 1);
    #2 reset = 1'b0;
    #1 check("rst_async_outs", all_outs, 0);
    @(posedge clk); #1;
    check("rst_held_outs", all_outs, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_idle_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b0; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; poison = 1'b0;

    for (int i = 0; i < 7; i++) tbl[i] = '0;
    for (int c = 0; c < int'(N); c++) tbl[0].x[c] = 8'(c + 1);
    for (int k = 0; k < int'(M * N); k++) tbl[0].a[k] = 8'(k + 1);
    tbl[0].y[0] = 16'd14; tbl[0].y[1] = 16'd32; tbl[0].y[2] = 16'd50;
    tbl[1] = tbl[0]; tbl[1].gap = 2'd1;
    tbl[2] = tbl[0]; tbl[2].bp = 2'd1;
    tbl[3].x[0] = 8'(-1); tbl[3].x[1] = 8'(-128); tbl[3].x[2] = 8'(127);
    for (int k = 0; k < int'(M * N); k++) tbl[3].a[k] = 8'(-128);
    for (int r = 0; r < int'(M); r++) tbl[3].y[r] = 16'd256;
    tbl[4] = tbl[0]; tbl[4].poke = 1'b1;
    for (int c = 0; c < int'(N); c++) tbl[5].x[c] = 8'(127);
    for (int k = 0; k < int'(M * N); k++) tbl[5].a[k] = 8'(127);
    for (int r = 0; r < int'(M); r++) tbl[5].y[r] = 16'(-17149);
    tbl[6].x[0] = 8'(5); tbl[6].x[1] = 8'(-7); tbl[6].x[2] = 8'(9);
    for (int k = 0; k < int'(M * N); k++) tbl[6].a[k] = (k % 4 == 0) ? 8'(1) : 8'(0);
    tbl[6].y[0] = 16'(5); tbl[6].y[1] = 16'(-7); tbl[6].y[2] = 16'(9);
    tbl[6].gap = 2'd2; tbl[6].bp = 2'd2; tbl[6].poke = 1'b1;

    repeat (3) @(posedge clk);
    #1 check("reset_outs", all_outs, 0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("tbl%0d", i));

    for (int n = 0; n < 6; n++) begin
      v = '0;
      for (int c = 0; c < int'(N); c++) v.x[c] = 8'($urandom);
      for (int k = 0; k < int'(M * N); k++) v.a[k] = 8'($urandom);
      v.y    = ref_y(v.x, v.a);
      v.gap  = 2'd2;
      v.bp   = 2'd2;
      v.poke = 1'($urandom_range(0, 1));
      run(v, $sformatf("rnd%0d", n));
    end

    reset_mid_compute(tbl[0]);
    run(tbl[0], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
